// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the dual-clock FIFO pointer controllers.
//   - PTR_WIDTH_DEF : default address width (depth = 2**PTR_WIDTH_DEF)
//   - ptr_t         : pointer type at the default width (address + wrap bit)
//   - bin2gray      : binary to reflected Gray code
//   - gray2bin      : reflected Gray code to binary
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int PTR_WIDTH_DEF = 4;

    typedef logic [PTR_WIDTH_DEF:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return (b >> 1) ^ b;
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PTR_WIDTH_DEF] = g[PTR_WIDTH_DEF];
        for (int i = PTR_WIDTH_DEF - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// ---------------------------------------------------------------------------
// gray2bin_conv
//   Parameterized Gray-to-binary decoder (XOR prefix chain from the MSB).
//   Purely combinational; shared by the write- and read-side controllers.
//   Ports:
//     i_gray [W-1:0] : Gray-coded pointer
//     o_bin  [W-1:0] : binary equivalent
// ---------------------------------------------------------------------------
module gray2bin_conv #(
    parameter int W = 5
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);

    logic w_acc;

    // Running XOR walks down from the MSB; each step produces one binary bit.
    always_comb begin
        o_bin = '0;
        w_acc = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            w_acc    = w_acc ^ i_gray[i];
            o_bin[i] = w_acc;
        end
    end

endmodule

// File: rtl/wr_ptr_full_ctrl.sv
// ---------------------------------------------------------------------------
// wr_ptr_full_ctrl
//   Write-side pointer and flag controller of the dual-clock FIFO. Runs fully
//   in the write clock domain. Accepts writes while not full, advances a
//   binary/Gray write pointer pair and derives full / almost-full / level from
//   the synchronized Gray read pointer. Overflow is a sticky flag.
//   Ports:
//     i_clk          : write-domain clock
//     i_rst_n        : asynchronous active-low reset
//     i_wr_req       : producer write request
//     i_rptr_sync    : Gray read pointer, already synchronized into i_clk
//     i_clr_ovf      : clear strobe for o_overflow
//     o_wr_en        : write accepted this cycle (memory write enable)
//     o_waddr        : memory write address of the current-cycle write
//     o_wptr_gray    : registered Gray write pointer to the read domain
//     o_full         : registered full flag
//     o_almost_full  : registered flag, level >= AFULL_THRESH
//     o_wr_level     : registered fill level, 0..2**PTR_WIDTH
//     o_overflow     : sticky, set by a write attempt while full
// ---------------------------------------------------------------------------
module wr_ptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int PTR_WIDTH    = PTR_WIDTH_DEF,
    parameter int AFULL_THRESH = 12
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_wr_req,
    input  logic [PTR_WIDTH:0]   i_rptr_sync,
    input  logic                 i_clr_ovf,
    output logic                 o_wr_en,
    output logic [PTR_WIDTH-1:0] o_waddr,
    output logic [PTR_WIDTH:0]   o_wptr_gray,
    output logic                 o_full,
    output logic                 o_almost_full,
    output logic [PTR_WIDTH:0]   o_wr_level,
    output logic                 o_overflow
);

    localparam logic [PTR_WIDTH:0] AF_THRESH = (PTR_WIDTH + 1)'(AFULL_THRESH);

    logic [PTR_WIDTH:0] r_wbin;
    logic [PTR_WIDTH:0] r_wptr_gray;
    logic               r_full;
    logic               r_almost_full;
    logic [PTR_WIDTH:0] r_wr_level;
    logic               r_overflow;

    logic               w_wr_en;
    logic [PTR_WIDTH:0] w_wbin_next;
    logic [PTR_WIDTH:0] w_wgray_next;
    logic [PTR_WIDTH:0] w_rbin;
    logic [PTR_WIDTH:0] w_rptr_full_pat;
    logic               w_full_next;
    logic [PTR_WIDTH:0] w_level_next;
    logic               w_afull_next;

    gray2bin_conv #(
        .W (PTR_WIDTH + 1)
    ) u_rptr_dec (
        .i_gray (i_rptr_sync),
        .o_bin  (w_rbin)
    );

    assign w_wr_en      = i_wr_req & ~r_full;
    // Wrap from all-ones to zero is intended; the extra MSB tracks laps.
    assign w_wbin_next  = r_wbin + (PTR_WIDTH + 1)'(w_wr_en);
    assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;

    // In Gray code a pointer exactly one lap ahead differs in the top two
    // bits only, so full is a compare against the read pointer with both
    // MSBs flipped.
    assign w_rptr_full_pat = {~i_rptr_sync[PTR_WIDTH:PTR_WIDTH-1],
                              i_rptr_sync[PTR_WIDTH-2:0]};
    assign w_full_next     = (w_wgray_next == w_rptr_full_pat);

    assign w_level_next = w_wbin_next - w_rbin;
    assign w_afull_next = (w_level_next >= AF_THRESH);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wbin        <= '0;
            r_wptr_gray   <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_wr_level    <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_wbin        <= w_wbin_next;
            r_wptr_gray   <= w_wgray_next;
            r_full        <= w_full_next;
            r_almost_full <= w_afull_next;
            r_wr_level    <= w_level_next;
            // Set beats clear so a refused write is never lost.
            if (i_wr_req && r_full)
                r_overflow <= 1'b1;
            else if (i_clr_ovf)
                r_overflow <= 1'b0;
        end
    end

    assign o_wr_en       = w_wr_en;
    assign o_waddr       = r_wbin[PTR_WIDTH-1:0];
    assign o_wptr_gray   = r_wptr_gray;
    assign o_full        = r_full;
    assign o_almost_full = r_almost_full;
    assign o_wr_level    = r_wr_level;
    assign o_overflow    = r_overflow;

endmodule

// File: doc/wr_ptr_full_ctrl.md
# wr_ptr_full_ctrl

Write-side pointer and flag controller for the team's dual-clock FIFO, running entirely in the write clock domain. It accepts write requests, gates them against the FIFO state, and advances a binary/Gray write pointer pair. Full, almost-full, fill level and a sticky overflow flag are derived from the Gray read pointer, which arrives already synchronized through `two_ff_sync`. The registered Gray write pointer output feeds the read-domain `two_ff_sync`. The write address drives the FIFO memory.

## Interface
- `PTR_WIDTH`, default 4: address width; FIFO depth is 2^PTR_WIDTH (16).
- `AFULL_THRESH`, default 12: fill level at which `almost_full` asserts; legal range 1..2^PTR_WIDTH.

Ports:
- `clk` in 1: write-domain clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `wr_req` in 1: write request from the producer.
- `rptr_sync` in PTR_WIDTH+1: Gray-coded read pointer, already synchronized into `clk`.
- `clr_ovf` in 1: clear strobe for `overflow`.
- `wr_en` out 1: write accepted this cycle; memory write enable.
- `waddr` out PTR_WIDTH: memory write address.
- `wptr_gray` out PTR_WIDTH+1: registered Gray write pointer, driven to the read domain.
- `full` out 1: registered full flag.
- `almost_full` out 1: registered flag, high when level ≥ `AFULL_THRESH`.
- `wr_level` out PTR_WIDTH+1: registered fill level, 0..2^PTR_WIDTH.
- `overflow` out 1: sticky flag, set by a write attempt while full.

## Operation
- State registers:
  - `wbin`, PTR_WIDTH+1 bits, binary.
  - `wptr_gray`, `full`, `almost_full`, `wr_level`, `overflow`.
- `wr_en` = `wr_req` & ~`full`. This is combinational from the registered `full`.
- `wbin_next` = `wbin` + `wr_en`, wrapping modulo 2^(PTR_WIDTH+1). The wrap from all-ones to 0 is normal operation.
- `wgray_next` = (`wbin_next` >> 1) ^ `wbin_next`.
- `waddr` = `wbin[PTR_WIDTH-1:0]`, which is the address of the current-cycle write.
- `full_next` is true when `wgray_next` equals `rptr_sync` with its two MSBs inverted and the remaining bits unchanged.
- Level computation:
  - `rbin` = Gray-to-binary of `rptr_sync`.
  - `level_next` = (`wbin_next` − `rbin`) mod 2^(PTR_WIDTH+1).
  - `almost_full_next` = (`level_next` ≥ `AFULL_THRESH`).
- `overflow` behaviour:
  - Set on any cycle with `wr_req` & `full`.
  - Cleared by `clr_ovf`.
  - If set and clear occur in the same cycle, set wins.
- A read-pointer advance alone, with no write, still updates `full`, `level` and `almost_full` on the next edge.
- `rptr_sync` is treated as valid Gray code. No checking of the read pointer is performed.

## Timing
- Reset, asynchronous, mid-operation included: `wbin`=0, `wptr_gray`=0, `full`=0, `almost_full`=0, `wr_level`=0, `overflow`=0.
  - Consequently `wr_en` = `wr_req` and `waddr`=0 immediately.
  - Any in-flight write is discarded.
- `wr_en` has 0-cycle latency relative to `wr_req`.
- `wptr_gray`, `full`, `wr_level` and `almost_full` reflect a write on the edge that accepts it, i.e. 1 cycle later.
- `full` rises on the same edge that accepts the 2^PTR_WIDTH-th outstanding write. The next request is therefore refused with no overshoot.
- A change on `rptr_sync` is reflected in the flags 1 cycle later. The 2-cycle synchronizer delay upstream makes `full` pessimistic, never optimistic.
- A simultaneous write and read-pointer advance at full-minus-one leaves level unchanged and `full` low.
- `overflow` is visible 1 cycle after the refused request.

## Structure
- Shared package `fifo_pkg`:
  - `bin2gray` and `gray2bin` functions.
  - Default `PTR_WIDTH` constant.
  - Pointer-width typedef.
- One sub-module, `gray2bin_conv`: a parameterized XOR prefix chain for `rptr_sync` decoding, reused by the read-side controller.
- Everything else is flat in this module.

## Test plan
- **Reset:** pulse `rst_n` low mid-burst, asynchronously between edges → all outputs 0 immediately; `waddr`=0; `wr_en` follows `wr_req`.
- **Fill with `rptr_sync`=0:** 16 consecutive `wr_req` →
  - `waddr` goes 0..15.
  - After the 16th edge: `wbin`=10000, `wptr_gray`=11000, `full`=1, `wr_level`=16.
  - 17th request gives `wr_en`=0; `overflow`=1 next cycle.
- **Almost-full:** with `AFULL_THRESH`=12 → `almost_full` rises on the edge accepting write 12 (`wr_level`=12); it falls once `rptr_sync` advances to Gray(1) with no write (`wr_level`=11).
- **Wrap-around:** write 40 words while `rptr_sync` tracks 4 behind →
  - `wbin` wraps 31→0.
  - `wr_level` stays 4.
  - `full` never asserts.
  - `wptr_gray` sequence is single-bit-change every step.
- **Simultaneous events:**
  - At level 15: write plus read advance → level stays 15, `full`=0.
  - While full: `wr_req` plus `clr_ovf` in the same cycle → `overflow` stays 1.
  - `clr_ovf` alone → `overflow`=0.
